hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It decides every cycle whether each pipeline register advances, holds, or is loaded with a bubble. Inputs are load-use hazards seen at ID/EX, taken branches/jumps resolved in EX (`pc_sel_EXIF`), and data-memory busy from MEM. It also owns a memory-wait watchdog that halts the core, and saturating stall/flush performance counters.

## Interface
- `TIMEOUT`, 16: consecutive `mem_busy_EXMEM` cycles that trigger HALT; legal range 2..2^16-1.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `rs1_IFID`, `rs2_IFID` in 5 each: source register fields of the instruction in ID.
- `rs1_used_IFID`, `rs2_used_IFID` in 1 each: the instruction in ID actually reads that source.
- `rd_IDEX` in 5: destination register of the instruction in EX.
- `mem_rd_en_IDEX` in 1: the instruction in EX is a load.
- `pc_sel_EXIF` in 1: a taken branch or jump is resolved in EX this cycle.
- `mem_busy_EXMEM` in 1: data memory has not completed the MEM-stage access.
- `pc_wr_en`, `ifid_wr_en`, `idex_wr_en`, `exmem_wr_en` out 1 each: 1 means the register loads on this edge; 0 means it holds.
- `ifid_flush`, `idex_flush` out 1 each: load a NOP bubble (all control 0) instead of the upstream data. Meaningful only when the matching `_wr_en` is 1.
- `halted` out 1: watchdog fired; the core is frozen.
- `stall_cnt` out CNT_W: number of cycles with `pc_wr_en`=0, excluding reset and HALT.
- `flush_cnt` out CNT_W: number of cycles with `ifid_flush`=1.

## Operation
- State register with values RUN (reset), WAIT and HALT. Also `wait_cnt` (16 bits), `stall_cnt` and `flush_cnt`.
- `lu_hazard` = `mem_rd_en_IDEX` & (`rd_IDEX`≠0) & ((`rs1_used_IFID` & `rs1_IFID`==`rd_IDEX`) | (`rs2_used_IFID` & `rs2_IFID`==`rd_IDEX`)).
- Outputs are combinational (Mealy) from the state and the current inputs. Decision priority, highest first:
  1. State HALT: all `_wr_en`=0, flushes=0, `halted`=1. Inputs are ignored. HALT is left only by reset.
  2. `mem_busy_EXMEM`=1 (RUN or WAIT): all `_wr_en`=0, flushes=0. Next state is WAIT, or HALT if `wait_cnt`==TIMEOUT-1. `wait_cnt` increments.
  3. `pc_sel_EXIF`=1: all `_wr_en`=1, `ifid_flush`=1, `idex_flush`=1. Any `lu_hazard` is ignored because the instruction in ID is squashed.
  4. `lu_hazard`=1: `pc_wr_en`=0, `ifid_wr_en`=0, `idex_wr_en`=1 with `idex_flush`=1 (one bubble), `exmem_wr_en`=1.
  5. Otherwise: all `_wr_en`=1, flushes=0.
- In rules 3–5 the next state is RUN and `wait_cnt` clears to 0. The WAIT→RUN exit cycle applies rules 3–5 in that same cycle; no extra dead cycle.
- `stall_cnt` increments when `pc_wr_en`=0 and state≠HALT. `flush_cnt` increments when `ifid_flush`=1. Both saturate at 2^CNT_W-1; they do not wrap.
- The forwarding unit is not touched. A load-use bubble of one cycle is sufficient because WB→EX forwarding exists.

## Timing
- Zero-cycle decision latency: enables and flushes are valid in the same cycle as their inputs and are sampled at the next edge.
- A load-use hazard costs exactly 1 stall cycle: the next cycle the load is in MEM and `lu_hazard` clears. A taken branch costs 2 bubbles.
- HALT entry: `mem_busy_EXMEM` high for TIMEOUT consecutive cycles. `halted` rises in cycle TIMEOUT+1 after busy first rose. A single low cycle of busy restarts the count.
- While `reset`=1: state=RUN, `wait_cnt`=0, counters=0, `halted`=0. All `_wr_en`=0 and flushes=0, forced combinationally.
- Reset during WAIT or HALT returns to RUN asynchronously. The first cycle after release behaves per rules 2–5.
- Busy simultaneous with `pc_sel_EXIF` or `lu_hazard`: busy wins. EX is frozen, so the branch or hazard is re-presented and acted on in the exit cycle.

## Test plan
- Load-use: load x5 in EX, ID reads rs1=x5 with `rs1_used_IFID`=1 → 1 cycle with `pc_wr_en`=`ifid_wr_en`=0 and `idex_flush`=1, then normal; `stall_cnt`=1. Same case with `rd_IDEX`=0 or `rs1_used_IFID`=0 → no stall.
- Taken branch: `pc_sel_EXIF`=1 together with a concurrent `lu_hazard` → all enables 1, both flushes 1, no stall; `flush_cnt`=1.
- Memory wait: busy for 3 cycles, with `pc_sel_EXIF`=1 throughout → 3 frozen cycles with no flush, then flush in the exit cycle; `stall_cnt`=3, `flush_cnt`=1, state returns to RUN.
- Watchdog at TIMEOUT=4: busy held high → `halted`=1 after the 4th busy cycle and stays 1 after busy drops. Busy pattern 3-high/1-low/3-high → never halts.
- Counter saturation with CNT_W=3: 9 stall cycles → `stall_cnt`=7.
- Async reset asserted mid-WAIT and mid-HALT → state RUN, counters and `halted` clear immediately, all enables 0 while `reset` is high.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage advance/hold/bubble decisions, memory-wait
// watchdog that freezes the core, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_IFID,
  input  logic [4:0]       rs2_IFID,
  input  logic             rs1_used_IFID,
  input  logic             rs2_used_IFID,
  input  logic [4:0]       rd_IDEX,
  input  logic             mem_rd_en_IDEX,
  input  logic             pc_sel_EXIF,
  input  logic             mem_busy_EXMEM,
  output logic             pc_wr_en,
  output logic             ifid_wr_en,
  output logic             idex_wr_en,
  output logic             exmem_wr_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        lu_hazard;

  assign lu_hazard = mem_rd_en_IDEX && (rd_IDEX != 5'd0) &&
                     ((rs1_used_IFID && (rs1_IFID == rd_IDEX)) ||
                      (rs2_used_IFID && (rs2_IFID == rd_IDEX)));

  assign halted = (state == HALT);

  always_comb begin
    pc_wr_en     = 1'b0;
    ifid_wr_en   = 1'b0;
    idex_wr_en   = 1'b0;
    exmem_wr_en  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    if (reset || state == HALT) begin
      state_nxt = state;
    end else if (mem_busy_EXMEM) begin
      // Busy outranks branch and hazard: EX is frozen, so they are re-presented at exit.
      state_nxt    = (wait_cnt == 16'(TIMEOUT - 1)) ? HALT : WAIT;
      wait_cnt_nxt = wait_cnt + 16'd1;
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = 16'd0;
      if (pc_sel_EXIF) begin
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        idex_wr_en  = 1'b1;
        exmem_wr_en = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (lu_hazard) begin
        idex_wr_en  = 1'b1;
        idex_flush  = 1'b1;
        exmem_wr_en = 1'b1;
      end else begin
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        idex_wr_en  = 1'b1;
        exmem_wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 16'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state != HALT && !pc_wr_en && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized plus scripted stimulus against a behavioural model of hazard_ctrl
// (TIMEOUT=4, CNT_W=3 to exercise watchdog and counter saturation quickly).
module tb_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1_IFID = '0, rs2_IFID = '0, rd_IDEX = '0;
  logic rs1_used_IFID = 1'b0, rs2_used_IFID = 1'b0;
  logic mem_rd_en_IDEX = 1'b0, pc_sel_EXIF = 1'b0, mem_busy_EXMEM = 1'b0;
  logic pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_used_IFID(rs1_used_IFID), .rs2_used_IFID(rs2_used_IFID),
    .rd_IDEX(rd_IDEX), .mem_rd_en_IDEX(mem_rd_en_IDEX),
    .pc_sel_EXIF(pc_sel_EXIF), .mem_busy_EXMEM(mem_busy_EXMEM),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .idex_wr_en(idex_wr_en),
    .exmem_wr_en(exmem_wr_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: halt flag, length of the current busy run, event counts.
  bit m_halted = 1'b0;
  int m_run    = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Called just after a falling edge; drives one cycle of inputs and checks it.
  task automatic step(input bit rst, input bit busy, input bit psel, input bit ld,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit u1, input bit u2);
    logic [6:0] exp_o;
    bit lu, halt_next;
    reset = rst; mem_busy_EXMEM = busy; pc_sel_EXIF = psel; mem_rd_en_IDEX = ld;
    rd_IDEX = rd; rs1_IFID = r1; rs2_IFID = r2; rs1_used_IFID = u1; rs2_used_IFID = u2;
    #2;
    halt_next = m_halted;
    lu = ld && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    if (rst) begin
      m_halted = 0; m_run = 0; m_stall = 0; m_flush = 0; halt_next = 0;
      exp_o = 7'b0000_00_0;
    end else if (m_halted) begin
      exp_o = 7'b0000_00_1;
    end else if (busy) begin
      exp_o = 7'b0000_00_0;
      m_run++;
      m_stall = sat_inc(m_stall);
      if (m_run == TIMEOUT) halt_next = 1;
    end else begin
      m_run = 0;
      if (psel) begin
        exp_o = 7'b1111_11_0;
        m_flush = sat_inc(m_flush);
      end else if (lu) begin
        exp_o = 7'b0011_01_0;
        m_stall = sat_inc(m_stall);
      end else begin
        exp_o = 7'b1111_00_0;
      end
    end
    chk("outputs", {25'b0, pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en,
                    ifid_flush, idex_flush, halted}, {25'b0, exp_o});
    if (rst) begin
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    end
    @(posedge clk); #1;
    m_halted = halt_next;
    chk("halted", 32'(halted), 32'(m_halted));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(negedge clk);
  endtask

  task automatic idle(input bit busy, input bit psel);
    step(1'b0, busy, psel, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // Load-use on rs1, then the same with rd=x0 and with rs1 unused.
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0);
    idle(0, 0);
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd1, 1, 0);
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0);
    step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
    // Taken branch with concurrent hazard.
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 0);
    // Memory wait of 3 cycles with branch held high, then exit with flush.
    repeat (3) idle(1, 1);
    idle(0, 1);
    idle(0, 0);
    // Watchdog: 3-high/1-low/3-high never halts.
    do_reset();
    repeat (3) idle(1, 0);
    idle(0, 0);
    repeat (3) idle(1, 0);
    idle(0, 0);
    // Busy held: halts after the 4th busy cycle, stays halted when busy drops.
    repeat (5) idle(1, 0);
    repeat (3) step(0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
    do_reset();
    // Reset mid-WAIT.
    repeat (2) idle(1, 0);
    do_reset();
    // Counter saturation: 9 load-use stalls.
    repeat (9) step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    repeat (9) idle(0, 1);
    do_reset();
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
